pll_reconfig_sequencer: RTL
===========================

// Module: pll_reconfig_sequencer
// PURPOSE
// Drives the Avalon-MM management port of the Cyclone V PLL reconfiguration core. It rewrites the N, M and NUM_CLOCKS C counters of a reconfigurable PLL from requested integer divide values.
// After the writes it starts reconfiguration, polls for completion and waits for the PLL to relock.
// Sits between the frequency-select logic and the reconfig core that feeds reconfig_to_pll.
// PARAMETERS
// NUM_CLOCKS    1      number of C counters rewritten (1..18), counter k written with index k
// DIV_W         9      width of each requested divide value (legal 1..511)
// LOCK_TIMEOUT  65535  refclk cycles allowed for status poll and, separately, for relock
// LOCK_STABLE   16     consecutive synchronised locked cycles required before done
// PORTS
// refclk           in   1             management clock, all logic on rising edge
// rst              in   1             asynchronous, active-high reset
// req_valid        in   1             reconfiguration request
// req_ready        out  1             high only in IDLE; request accepted on req_valid&&req_ready
// req_n_div        in   DIV_W         N divide value
// req_m_div        in   DIV_W         M divide value
// req_c_div        in   NUM_CLOCKS*DIV_W  C divide values, counter k at [k*DIV_W +: DIV_W]
// done             out  1             one-cycle pulse when sequence ends (success or error)
// err_code         out  2             0 ok, 1 illegal divider, 2 status timeout, 3 lock timeout; held until next accept
// busy             out  1             high from accept until done
// pll_locked       in   1             PLL locked, asynchronous to refclk
// locked_sync      out  1             2-FF synchronised pll_locked
// mgmt_address     out  6             reconfig core register address
// mgmt_write       out  1             write strobe
// mgmt_read        out  1             read strobe
// mgmt_writedata   out  32            write data
// mgmt_readdata    in   32            read data
// mgmt_waitrequest in   1             core stall
// BEHAVIOUR
// - Reset: req_ready=1 after release, busy=0, done=0, err_code=0, mgmt_write=mgmt_read=0, mgmt_address=0, mgmt_writedata=0, locked_sync=0.
// - Accept: all req_* inputs latched on the accept cycle; later changes ignored. req_valid while busy is ignored.
// - Validation, one cycle after accept: any divider 0 gives err_code=1 and done. No bus access occurs.
// - Encoding per divider D: hi=ceil(D/2), lo=floor(D/2), each field mod 256 (256 is encoded 0), odd=D[0], bypass=(D==1).
// - For D==1: hi=lo=1 and bypass=1.
// - Counter word: [17] odd, [16] bypass, [15:8] hi, [7:0] lo. C words also carry index k in [22:18].
// - States: IDLE -> CHECK -> WR_MODE -> WR_N -> WR_M -> WR_C (k=0..NUM_CLOCKS-1) -> WR_START -> POLL -> WAIT_LOCK -> IDLE.
// - WR_MODE writes addr 0x00 = 1 (polling mode). WR_N writes 0x03, WR_M writes 0x04, WR_C writes 0x05 per counter. WR_START writes 0x02 = 1.
// - Bus rule: a write or read is complete only in a cycle with strobe=1 and waitrequest=0.
// - Address, data and strobe are held stable while waitrequest=1. Strobe is deasserted for at least 1 cycle between transfers.
// - POLL reads 0x01 and samples readdata on completion. If bit0=1, go to WAIT_LOCK. Otherwise re-issue the read.
// - POLL: exceeding LOCK_TIMEOUT cycles gives err_code=2.
// - WAIT_LOCK: the stable counter counts cycles with locked_sync=1 and clears to 0 when locked_sync drops.
// - WAIT_LOCK succeeds on reaching LOCK_STABLE. Exceeding LOCK_TIMEOUT cycles in this state gives err_code=3.
// - done pulses in the cycle the FSM returns to IDLE. req_ready rises in the same cycle.
// - Minimum latency, accept to done, with waitrequest always 0 and locked already high: 2*(4+NUM_CLOCKS) + 2 + LOCK_STABLE + 2 cycles.
// - Reset mid-sequence: strobes drop immediately (asynchronous reset) and the FSM returns to IDLE. No done pulse.
// - Timeout and stable counters are wide enough for LOCK_TIMEOUT. They reset on every state entry.
// TESTING
// - Reset: assert rst mid-WR_M -> mgmt_write=0 at once; req_ready=1, err_code=0 after release; no done.
// - N=1, M=8, C0=4, waitrequest=0, status bit0=1 on first read, locked high -> writes in order:
//   0x00<-1, 0x03<-0x00010101, 0x04<-0x00000404, 0x05<-0x00000202, 0x02<-1;
//   then done with err_code=0.
// - NUM_CLOCKS=3, C2=5 -> C2 write data 0x000A0302. C0=511 -> 0x00000 0FF with hi field 0x00, i.e. data 0x000200FF.
// - waitrequest high 3 cycles on WR_N -> address and writedata held 4 cycles. Write counted once. Order unchanged.
// - M=0 -> done 1 cycle after CHECK, err_code=1, no mgmt strobe. Next valid request clears err_code to 0.
// - pll_locked held low -> err_code=3 exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry.
//   Toggling locked every 8 cycles with LOCK_STABLE=16 also ends in err_code=3.

Source files
------------

// File: rtl/pll_reconfig_sequencer.sv
// Rewrites the N, M and C counters of a reconfigurable PLL through the reconfig core's
// Avalon-MM management port, starts reconfiguration, polls for completion and waits for relock.
module pll_reconfig_sequencer #(
    parameter int NUM_CLOCKS   = 1,
    parameter int DIV_W        = 9,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 16
) (
    input  logic                        refclk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [DIV_W-1:0]            req_n_div,
    input  logic [DIV_W-1:0]            req_m_div,
    input  logic [NUM_CLOCKS*DIV_W-1:0] req_c_div,
    output logic                        done,
    output logic [1:0]                  err_code,
    output logic                        busy,
    input  logic                        pll_locked,
    output logic                        locked_sync,
    output logic [5:0]                  mgmt_address,
    output logic                        mgmt_write,
    output logic                        mgmt_read,
    output logic [31:0]                 mgmt_writedata,
    input  logic [31:0]                 mgmt_readdata,
    input  logic                        mgmt_waitrequest,
    output logic [3:0]                  dbg_state
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_START, S_POLL, S_WAIT_LOCK
    } state_t;

    state_t                    state_q;
    logic [DIV_W-1:0]          n_q, m_q;
    logic [NUM_CLOCKS*DIV_W-1:0] c_q;
    logic [4:0]                k_q;
    logic [TW-1:0]             tmo_q;
    logic [SW-1:0]             stable_q;
    logic                      status_q;
    logic [5:0]                addr_q;
    logic [31:0]               wdata_q;
    logic                      write_q, read_q, done_q, busy_q;
    logic [1:0]                err_q;
    logic                      sync1_q, sync2_q;

    logic                      div_bad;
    logic [4:0]                c_next_idx;
    logic [DIV_W-1:0]          c_next_div;
    logic                      unused_rd;

    // Only the completion flag of the status register matters.
    assign unused_rd = ^mgmt_readdata[31:1];

    // D==1 uses bypass with hi=lo=1 and no odd flag; otherwise hi/lo split with odd correction.
    function automatic logic [31:0] enc_word(input logic [DIV_W-1:0] d, input logic [4:0] idx);
        logic [31:0] dw;
        logic [7:0]  hi, lo;
        dw = 32'(d);
        hi = 8'((dw + 32'd1) >> 1);
        lo = 8'(dw >> 1);
        if (dw == 32'd1) return {9'd0, idx, 2'b01, 8'd1, 8'd1};
        return {9'd0, idx, dw[0], 1'b0, hi, lo};
    endfunction

    always_comb begin
        div_bad    = (n_q == '0) || (m_q == '0);
        c_next_idx = k_q + 5'd1;
        c_next_div = '0;
        for (int k = 0; k < NUM_CLOCKS; k++) begin
            if (c_q[k*DIV_W +: DIV_W] == '0) div_bad = 1'b1;
            if (5'(k) == c_next_idx) c_next_div = c_q[k*DIV_W +: DIV_W];
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Each write state: strobe phase until waitrequest drops, then one idle gap cycle
    // during which the next transfer is loaded.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            tmo_q    <= '0;
            stable_q <= '0;
            status_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        n_q     <= req_n_div;
                        m_q     <= req_m_div;
                        c_q     <= req_c_div;
                        err_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (div_bad) begin
                        err_q   <= 2'd1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        addr_q  <= 6'h00;
                        wdata_q <= 32'd1;
                        write_q <= 1'b1;
                        state_q <= S_WR_MODE;
                    end
                end
                S_WR_MODE: begin
                    if (write_q) begin
                        if (!mgmt_waitrequest) write_q <= 1'b0;
                    end else begin
                        addr_q  <= 6'h03;
                        wdata_q <= enc_word(n_q, 5'd0);
                        write_q <= 1'b1;
                        state_q <= S_WR_N;
                    end
                end
                S_WR_N: begin
                    if (write_q) begin
                        if (!mgmt_waitrequest) write_q <= 1'b0;
                    end else begin
                        addr_q  <= 6'h04;
                        wdata_q <= enc_word(m_q, 5'd0);
                        write_q <= 1'b1;
                        state_q <= S_WR_M;
                    end
                end
                S_WR_M: begin
                    if (write_q) begin
                        if (!mgmt_waitrequest) write_q <= 1'b0;
                    end else begin
                        addr_q  <= 6'h05;
                        wdata_q <= enc_word(c_q[DIV_W-1:0], 5'd0);
                        write_q <= 1'b1;
                        k_q     <= 5'd0;
                        state_q <= S_WR_C;
                    end
                end
                S_WR_C: begin
                    if (write_q) begin
                        if (!mgmt_waitrequest) write_q <= 1'b0;
                    end else if (k_q == 5'(NUM_CLOCKS - 1)) begin
                        addr_q  <= 6'h02;
                        wdata_q <= 32'd1;
                        write_q <= 1'b1;
                        state_q <= S_WR_START;
                    end else begin
                        k_q     <= c_next_idx;
                        wdata_q <= enc_word(c_next_div, c_next_idx);
                        write_q <= 1'b1;
                    end
                end
                S_WR_START: begin
                    if (write_q) begin
                        if (!mgmt_waitrequest) write_q <= 1'b0;
                    end else begin
                        addr_q   <= 6'h01;
                        read_q   <= 1'b1;
                        status_q <= 1'b0;
                        tmo_q    <= '0;
                        state_q  <= S_POLL;
                    end
                end
                S_POLL: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                        read_q  <= 1'b0;
                        err_q   <= 2'd2;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (read_q) begin
                        if (!mgmt_waitrequest) begin
                            read_q   <= 1'b0;
                            status_q <= mgmt_readdata[0];
                        end
                    end else if (status_q) begin
                        tmo_q    <= '0;
                        stable_q <= '0;
                        state_q  <= S_WAIT_LOCK;
                    end else begin
                        read_q <= 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    tmo_q    <= tmo_q + 1'b1;
                    stable_q <= sync2_q ? stable_q + 1'b1 : '0;
                    if (sync2_q && stable_q == SW'(LOCK_STABLE - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                        err_q   <= 2'd3;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign done           = done_q;
    assign err_code       = err_q;
    assign busy           = busy_q;
    assign locked_sync    = sync2_q;
    assign mgmt_address   = addr_q;
    assign mgmt_write     = write_q;
    assign mgmt_read      = read_q;
    assign mgmt_writedata = wdata_q;
    assign dbg_state      = state_q;

endmodule
